bcd_to_binary: RTL and testbench

Sequential BCD-to-binary decoder: the inverse of the score BCD encoder. It accepts a four-digit packed-BCD value (thousands, hundreds, tens, ones) and converts it with reverse double-dabble, one bit per cycle, into an OUT_W-bit binary value. It uses a start/done handshake and sits beside the score path, where it converts digit-entered values such as preset scores or targets back into binary counters.

---
 rtl/bcd_to_binary.sv | 120 ++++++++++++
 tb/tb_bcd_to_binary.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential four-digit packed-BCD to binary converter.
// Reverse double-dabble, one bit per cycle, with a start/done handshake.
// Optional build macro BCD2BIN_SATURATE_EN: clamp binary to all ones on overflow
// (undefined: binary is the value modulo 2^OUT_W).
module bcd_to_binary #(
    parameter int unsigned OUT_W = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [3:0]       thousands,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] binary,
    output logic             overflow,
    output logic             invalid
);

    typedef enum logic [1:0] {StIdle, StCheck, StShift, StDone} state_t;

    state_t      state_q;
    logic [15:0] bcd_q;
    logic [13:0] acc_q;
    logic [3:0]  cnt_q;

    logic [29:0]      shifted;
    logic [15:0]      bcd_sh;
    logic [15:0]      bcd_adj;
    logic [13:0]      acc_sh;
    logic             digit_bad;
    logic             ovf_next;
    logic [OUT_W-1:0] bin_next;

    // One reverse double-dabble step: shift {bcd, acc} right, then correct nibbles >= 8
    always_comb begin
        shifted = {1'b0, bcd_q, acc_q[13:1]};
        bcd_sh  = shifted[29:14];
        acc_sh  = shifted[13:0];
        bcd_adj = bcd_sh;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    // Digit validity and result formatting for the final shift
    always_comb begin
        digit_bad = (bcd_q[3:0] > 4'd9) || (bcd_q[7:4] > 4'd9) ||
                    (bcd_q[11:8] > 4'd9) || (bcd_q[15:12] > 4'd9);
        // Shifting out the kept bits leaves only the excess; zero for OUT_W = 14
        ovf_next = (acc_sh >> OUT_W) != 14'd0;
`ifdef BCD2BIN_SATURATE_EN
        bin_next = ovf_next ? {OUT_W{1'b1}} : acc_sh[OUT_W-1:0];
`else
        bin_next = acc_sh[OUT_W-1:0];
`endif
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            bcd_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            binary   <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                // DONE accepts a new request exactly like IDLE for back-to-back use
                StIdle, StDone: begin
                    if (start) begin
                        bcd_q   <= {thousands, hundreds, tens, ones};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StCheck;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCheck: begin
                    if (digit_bad) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        binary   <= '0;
                        overflow <= 1'b0;
                        invalid  <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    bcd_q <= bcd_adj;
                    acc_q <= acc_sh;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd13) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        binary   <= bin_next;
                        overflow <= ovf_next;
                        invalid  <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed testbench for bcd_to_binary (OUT_W = 10 and a 14-bit instance).
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic        busy, done, overflow, invalid;
    logic [9:0]  binary;
    logic        busy14, done14, overflow14, invalid14;
    logic [13:0] binary14;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, nbusy, ndone;

    always #5 clk = ~clk;

    bcd_to_binary #(.OUT_W(10)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .busy(busy), .done(done), .binary(binary), .overflow(overflow), .invalid(invalid)
    );

    bcd_to_binary #(.OUT_W(14)) dut14 (
        .clk(clk), .resetn(resetn), .start(start),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .busy(busy14), .done(done14), .binary(binary14), .overflow(overflow14),
        .invalid(invalid14)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                              input logic [3:0] o);
        thousands = t;
        hundreds  = h;
        tens      = te;
        ones      = o;
    endtask

    // Start pulse for one edge (the accepting edge); returns just after it
    task automatic launch(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                          input logic [3:0] o);
        set_digits(t, h, te, o);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_digits(4'hF, 4'hF, 4'hF, 4'hF);
    endtask

    // lat counts edges after the accepting edge: lat = k means done seen at E+k
    task automatic wait_done(input int lat0, output int lat_o, output int nbusy_o);
        lat_o   = lat0;
        nbusy_o = 0;
        while (!done && lat_o < 40) begin
            if (busy) nbusy_o++;
            tick();
            lat_o++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        check_eq("reset_outputs", {busy, done, binary, overflow, invalid}, 0);
        resetn = 1'b1;
        tick();

        // Basic 0999
        launch(4'd0, 4'd9, 4'd9, 4'd9);
        wait_done(1, lat, nbusy);
        check_eq("basic_latency", lat, 16);
        check_eq("basic_busy_cycles", nbusy, 15);
        check_eq("basic_busy_at_done", busy, 0);
        check_eq("basic_binary", binary, 999);
        check_eq("basic_flags", {overflow, invalid}, 0);
        tick();
        check_eq("done_single_cycle", done, 0);
        check_eq("binary_held", binary, 999);

        // Boundaries
        launch(4'd1, 4'd0, 4'd2, 4'd3);
        wait_done(1, lat, nbusy);
        check_eq("b1023_binary", binary, 1023);
        check_eq("b1023_overflow", overflow, 0);
        tick();
        launch(4'd0, 4'd0, 4'd0, 4'd0);
        wait_done(1, lat, nbusy);
        check_eq("zero_binary", binary, 0);
        check_eq("zero_flags", {overflow, invalid}, 0);
        tick();

        // Overflow
        launch(4'd9, 4'd9, 4'd9, 4'd9);
        wait_done(1, lat, nbusy);
        check_eq("ovf_flag", overflow, 1);
`ifdef BCD2BIN_SATURATE_EN
        check_eq("ovf_binary_sat", binary, 1023);
`else
        check_eq("ovf_binary_wrap", binary, 783);
`endif
        check_eq("w14_done", done14, 1);
        check_eq("w14_binary", binary14, 9999);
        check_eq("w14_overflow", overflow14, 0);
        tick();

        // Invalid digit then valid
        launch(4'd0, 4'd1, 4'hA, 4'd3);
        wait_done(1, lat, nbusy);
        check_eq("inv_latency", lat, 2);
        check_eq("inv_flag", invalid, 1);
        check_eq("inv_binary", binary, 0);
        check_eq("inv_overflow", overflow, 0);
        tick();
        launch(4'd0, 4'd0, 4'd4, 4'd2);
        wait_done(1, lat, nbusy);
        check_eq("after_inv_binary", binary, 42);
        check_eq("after_inv_invalid", invalid, 0);
        tick();

        // Start while busy is ignored
        launch(4'd0, 4'd3, 4'd1, 4'd4);
        repeat (4) tick();
        set_digits(4'd0, 4'd7, 4'd7, 4'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(6, lat, nbusy);
        check_eq("ignored_latency", lat, 16);
        check_eq("ignored_binary", binary, 314);

        // Back-to-back: start held during the done cycle
        set_digits(4'd0, 4'd5, 4'd0, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("b2b_busy", busy, 1);
        wait_done(1, lat, nbusy);
        check_eq("b2b_latency", lat, 16);
        check_eq("b2b_binary", binary, 500);
        tick();

        // Reset mid-conversion
        launch(4'd0, 4'd9, 4'd0, 4'd9);
        repeat (6) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_eq("midreset_outputs", {busy, done, binary, overflow, invalid}, 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            tick();
        end
        check_eq("midreset_no_done", ndone, 0);
        launch(4'd0, 4'd1, 4'd2, 4'd8);
        wait_done(1, lat, nbusy);
        check_eq("post_reset_latency", lat, 16);
        check_eq("post_reset_binary", binary, 128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
